// File: rtl/ysyx_22041071_axi_w.sv
// AXI4 write-channel master: one CPU write request becomes
// one AW transaction, len+1 W beats and a B wait.
module ysyx_22041071_axi_w #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_aw_valid,
   output logic                cpu_aw_ready,
   input  logic [ID_W-1:0]     cpu_id,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [LEN_W-1:0]    cpu_len,
   input  logic [1:0]          cpu_size,
   input  logic                cpu_w_valid,
   output logic                cpu_w_ready,
   input  logic [DATA_W-1:0]   cpu_w_data,
   output logic                cpu_b_valid,
   output logic [1:0]          cpu_b_resp,
   input  logic                axi_aw_ready_i,
   output logic                axi_aw_valid_o,
   output logic [ID_W-1:0]     axi_aw_id_o,
   output logic [ADDR_W-1:0]   axi_aw_addr_o,
   output logic [LEN_W-1:0]    axi_aw_len_o,
   output logic [2:0]          axi_aw_size_o,
   output logic [1:0]          axi_aw_burst_o,
   output logic [2:0]          axi_aw_prot_o,
   output logic                axi_aw_lock_o,
   output logic [3:0]          axi_aw_cache_o,
   output logic [3:0]          axi_aw_qos_o,
   output logic [3:0]          axi_aw_region_o,
   output logic                axi_aw_user_o,
   input  logic                axi_w_ready_i,
   output logic                axi_w_valid_o,
   output logic [DATA_W-1:0]   axi_w_data_o,
   output logic [DATA_W/8-1:0] axi_w_strb_o,
   output logic                axi_w_last_o,
   output logic                axi_b_ready_o,
   input  logic                axi_b_valid_i,
   input  logic [1:0]          axi_b_resp_i,
   input  logic [ID_W-1:0]     axi_b_id_i
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        off_q;
   logic [LEN_W-1:0]  len_q;
   logic [2:0]        size_q;
   logic [LEN_W-1:0]  beat_cnt;

   logic              req_hs;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic [7:0]        strb_base;

   // B ID is deliberately not compared; the response is returned as-is
   logic              unused_bid;
   assign unused_bid = ^axi_b_id_i;

   assign req_hs = (state_q == S_IDLE) && cpu_aw_valid;
   assign aw_hs  = (state_q == S_ADDR) && axi_aw_ready_i;
   assign w_hs   = (state_q == S_DATA) && cpu_w_valid
                && axi_w_ready_i;
   assign b_hs   = (state_q == S_RESP) && axi_b_valid_i;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (cpu_aw_valid)   state_d = S_ADDR;
         S_ADDR: if (axi_aw_ready_i) state_d = S_DATA;
         S_DATA: if (w_hs && axi_w_last_o) state_d = S_RESP;
         S_RESP: if (axi_b_valid_i)  state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // latch request fields on acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         id_q   <= '0;
         addr_q <= '0;
         off_q  <= '0;
         len_q  <= '0;
         size_q <= '0;
      end else if (req_hs) begin
         id_q   <= cpu_id;
         addr_q <= {cpu_addr[ADDR_W-1:3], 3'b000};
         off_q  <= cpu_addr[2:0];
         len_q  <= cpu_len;
         size_q <= {1'b0, cpu_size};
      end
   end

   // beat counter: cleared on a new request, bumped per W handshake
   always_ff @(posedge clk) begin
      if (reset)      beat_cnt <= '0;
      else if (req_hs) beat_cnt <= '0;
      else if (w_hs)  beat_cnt <= beat_cnt + 1'b1;
   end

   // write response capture and one-cycle done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_b_valid <= 1'b0;
         cpu_b_resp  <= 2'b00;
      end else begin
         cpu_b_valid <= b_hs;
         if (b_hs) cpu_b_resp <= axi_b_resp_i;
      end
   end

   // byte-lane mask for the access size
   always_comb begin
      strb_base = 8'h00;
      unique case (size_q[1:0])
         2'b00: strb_base = 8'h01;
         2'b01: strb_base = 8'h03;
         2'b10: strb_base = 8'h0F;
         2'b11: strb_base = 8'hFF;
         default: strb_base = 8'h00;
      endcase
   end

   // handshake and channel outputs
   always_comb begin
      cpu_aw_ready   = (state_q == S_IDLE);
      axi_aw_valid_o = (state_q == S_ADDR);
      axi_w_valid_o  = (state_q == S_DATA) && cpu_w_valid;
      cpu_w_ready    = (state_q == S_DATA) && axi_w_ready_i;
      axi_w_last_o   = (state_q == S_DATA) && (beat_cnt == len_q);
      axi_b_ready_o  = (state_q == S_RESP);
      if (len_q == '0) begin
         axi_w_data_o = cpu_w_data << {off_q, 3'b000};
         axi_w_strb_o = STRB_W'(strb_base << off_q);
      end else begin
         axi_w_data_o = cpu_w_data;
         axi_w_strb_o = '1;
      end
   end

   assign axi_aw_id_o     = id_q;
   assign axi_aw_addr_o   = addr_q;
   assign axi_aw_len_o    = len_q;
   assign axi_aw_size_o   = size_q;
   assign axi_aw_burst_o  = 2'b01;
   assign axi_aw_prot_o   = 3'b000;
   assign axi_aw_lock_o   = 1'b0;
   assign axi_aw_cache_o  = 4'h0;
   assign axi_aw_qos_o    = 4'h0;
   assign axi_aw_region_o = 4'h0;
   assign axi_aw_user_o   = 1'b0;

endmodule

// File: tb/tb_ysyx_22041071_axi_w.sv
// Directed bench for the AXI write master: vector table of
// single-beat stores plus burst, back-pressure and reset sequences.
module tb_ysyx_22041071_axi_w;

   logic        clk;
   logic        reset;
   logic        cpu_aw_valid;
   logic        cpu_aw_ready;
   logic [3:0]  cpu_id;
   logic [63:0] cpu_addr;
   logic [7:0]  cpu_len;
   logic [1:0]  cpu_size;
   logic        cpu_w_valid;
   logic        cpu_w_ready;
   logic [63:0] cpu_w_data;
   logic        cpu_b_valid;
   logic [1:0]  cpu_b_resp;
   logic        axi_aw_ready_i;
   logic        axi_aw_valid_o;
   logic [3:0]  axi_aw_id_o;
   logic [63:0] axi_aw_addr_o;
   logic [7:0]  axi_aw_len_o;
   logic [2:0]  axi_aw_size_o;
   logic [1:0]  axi_aw_burst_o;
   logic [2:0]  axi_aw_prot_o;
   logic        axi_aw_lock_o;
   logic [3:0]  axi_aw_cache_o;
   logic [3:0]  axi_aw_qos_o;
   logic [3:0]  axi_aw_region_o;
   logic        axi_aw_user_o;
   logic        axi_w_ready_i;
   logic        axi_w_valid_o;
   logic [63:0] axi_w_data_o;
   logic [7:0]  axi_w_strb_o;
   logic        axi_w_last_o;
   logic        axi_b_ready_o;
   logic        axi_b_valid_i;
   logic [1:0]  axi_b_resp_i;
   logic [3:0]  axi_b_id_i;

   int total;
   int bad;

   ysyx_22041071_axi_w dut (
      .clk(clk), .reset(reset),
      .cpu_aw_valid(cpu_aw_valid), .cpu_aw_ready(cpu_aw_ready),
      .cpu_id(cpu_id), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
      .cpu_size(cpu_size),
      .cpu_w_valid(cpu_w_valid), .cpu_w_ready(cpu_w_ready),
      .cpu_w_data(cpu_w_data),
      .cpu_b_valid(cpu_b_valid), .cpu_b_resp(cpu_b_resp),
      .axi_aw_ready_i(axi_aw_ready_i),
      .axi_aw_valid_o(axi_aw_valid_o),
      .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o),
      .axi_aw_len_o(axi_aw_len_o), .axi_aw_size_o(axi_aw_size_o),
      .axi_aw_burst_o(axi_aw_burst_o),
      .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_lock_o(axi_aw_lock_o),
      .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_qos_o(axi_aw_qos_o),
      .axi_aw_region_o(axi_aw_region_o),
      .axi_aw_user_o(axi_aw_user_o),
      .axi_w_ready_i(axi_w_ready_i), .axi_w_valid_o(axi_w_valid_o),
      .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
      .axi_w_last_o(axi_w_last_o),
      .axi_b_ready_o(axi_b_ready_o), .axi_b_valid_i(axi_b_valid_i),
      .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  size;
      logic [63:0] data;
      logic [1:0]  resp;
      logic [63:0] exp_addr;
      logic [63:0] exp_data;
      logic [7:0]  exp_strb;
   } vec_t;

   vec_t vecs[5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_single(input vec_t v);
      chk("idle_aw_ready", cpu_aw_ready, 1);
      cpu_aw_valid = 1'b1;
      cpu_id = 4'h3;
      cpu_addr = v.addr;
      cpu_len = 8'd0;
      cpu_size = v.size;
      tick;
      cpu_aw_valid = 1'b0;
      cpu_addr = '1;
      cpu_size = 2'b00;
      cpu_len = 8'hFF;
      #1;
      chk("aw_valid", axi_aw_valid_o, 1);
      chk("aw_addr", axi_aw_addr_o, v.exp_addr);
      chk("aw_size", axi_aw_size_o, {1'b0, v.size});
      chk("aw_len", axi_aw_len_o, 0);
      chk("aw_burst", axi_aw_burst_o, 1);
      chk("aw_id", axi_aw_id_o, 4'h3);
      axi_aw_ready_i = 1'b1;
      tick;
      axi_aw_ready_i = 1'b0;
      cpu_w_valid = 1'b1;
      cpu_w_data = v.data;
      axi_w_ready_i = 1'b1;
      #1;
      chk("aw_valid_drop", axi_aw_valid_o, 0);
      chk("w_valid", axi_w_valid_o, 1);
      chk("cpu_w_ready", cpu_w_ready, 1);
      chk("w_data", axi_w_data_o, v.exp_data);
      chk("w_strb", axi_w_strb_o, v.exp_strb);
      chk("w_last", axi_w_last_o, 1);
      tick;
      cpu_w_valid = 1'b0;
      axi_w_ready_i = 1'b0;
      #1;
      chk("b_ready", axi_b_ready_o, 1);
      axi_b_valid_i = 1'b1;
      axi_b_resp_i = v.resp;
      tick;
      axi_b_valid_i = 1'b0;
      #1;
      chk("cpu_b_valid", cpu_b_valid, 1);
      chk("cpu_b_resp", cpu_b_resp, v.resp);
      chk("back_idle", cpu_aw_ready, 1);
      tick;
      chk("b_pulse_end", cpu_b_valid, 0);
   endtask

   logic [63:0] bd[4];
   logic [5:0]  pat;
   int          beat;

   initial begin
      total = 0;
      bad = 0;
      vecs[0] = '{64'h8000_0010, 2'b11, 64'h1122_3344_5566_7788, 2'b00,
                  64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF};
      vecs[1] = '{64'h8000_0005, 2'b00, 64'h0000_0000_0000_00AB, 2'b01,
                  64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20};
      vecs[2] = '{64'h8000_0006, 2'b01, 64'h0000_0000_0000_BEEF, 2'b00,
                  64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0};
      vecs[3] = '{64'h8000_0104, 2'b10, 64'h0000_0000_DEAD_BEEF, 2'b11,
                  64'h8000_0100, 64'hDEAD_BEEF_0000_0000, 8'hF0};
      vecs[4] = '{64'h0000_1003, 2'b11, 64'h1122_3344_5566_7788, 2'b00,
                  64'h0000_1000, 64'h4455_6677_8800_0000, 8'hF8};
      bd[0] = 64'hD0D0_0000_0000_0001;
      bd[1] = 64'hD1D1_0000_0000_0002;
      bd[2] = 64'hD2D2_0000_0000_0003;
      bd[3] = 64'hD3D3_0000_0000_0004;

      reset = 1'b1;
      cpu_aw_valid = 0; cpu_id = 0; cpu_addr = 0; cpu_len = 0;
      cpu_size = 0; cpu_w_valid = 0; cpu_w_data = 0;
      axi_aw_ready_i = 0; axi_w_ready_i = 0;
      axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = 0;
      tick;
      tick;
      chk("rst_aw_valid", axi_aw_valid_o, 0);
      chk("rst_w_valid", axi_w_valid_o, 0);
      chk("rst_b_ready", axi_b_ready_o, 0);
      chk("rst_cpu_b_valid", cpu_b_valid, 0);
      chk("rst_cpu_b_resp", cpu_b_resp, 0);
      chk("rst_aw_addr", axi_aw_addr_o, 0);
      chk("rst_aw_ready", cpu_aw_ready, 1);
      reset = 1'b0;
      tick;

      for (int i = 0; i < 5; i++) run_single(vecs[i]);

      // burst of 4 with W back-pressure 1,0,1,1,0,1
      cpu_aw_valid = 1; cpu_id = 4'h7;
      cpu_addr = 64'h8000_0200; cpu_len = 8'd3; cpu_size = 2'b11;
      tick;
      cpu_aw_valid = 0;
      #1;
      chk("burst_aw_len", axi_aw_len_o, 3);
      axi_aw_ready_i = 1;
      tick;
      axi_aw_ready_i = 0;
      pat = 6'b101101;
      beat = 0;
      for (int i = 0; i < 6; i++) begin
         axi_w_ready_i = pat[i];
         cpu_w_valid = 1;
         cpu_w_data = bd[beat];
         #1;
         chk("burst_w_valid", axi_w_valid_o, 1);
         chk("burst_last", axi_w_last_o, beat == 3);
         if (pat[i]) begin
            chk("burst_data", axi_w_data_o, bd[beat]);
            chk("burst_strb", axi_w_strb_o, 8'hFF);
         end
         tick;
         if (pat[i]) beat++;
      end
      #1;
      chk("burst_resp_state", axi_b_ready_o, 1);
      chk("burst_w_closed", axi_w_valid_o, 0);
      cpu_w_valid = 0; axi_w_ready_i = 0;
      axi_b_valid_i = 1; axi_b_resp_i = 2'b00;
      tick;
      axi_b_valid_i = 0;
      chk("burst_b_valid", cpu_b_valid, 1);
      tick;

      // AW held off 5 cycles, B held off 3 cycles
      cpu_aw_valid = 1; cpu_id = 4'h5;
      cpu_addr = 64'h8000_0040; cpu_len = 0; cpu_size = 2'b11;
      tick;
      cpu_aw_valid = 0;
      for (int k = 0; k < 5; k++) begin
         cpu_addr = 64'h111 * k;
         #1;
         chk("bp_aw_valid", axi_aw_valid_o, 1);
         chk("bp_aw_addr", axi_aw_addr_o, 64'h8000_0040);
         chk("bp_aw_id", axi_aw_id_o, 4'h5);
         tick;
      end
      axi_aw_ready_i = 1;
      tick;
      axi_aw_ready_i = 0;
      cpu_w_valid = 1; cpu_w_data = 64'h55; axi_w_ready_i = 1;
      tick;
      cpu_w_valid = 0; axi_w_ready_i = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bwait_b_ready", axi_b_ready_o, 1);
         chk("bwait_cpu_b", cpu_b_valid, 0);
         tick;
      end
      axi_b_valid_i = 1; axi_b_resp_i = 2'b10; axi_b_id_i = 4'hF;
      tick;
      axi_b_valid_i = 0; axi_b_id_i = 0;
      #1;
      chk("slverr_valid", cpu_b_valid, 1);
      chk("slverr_resp", cpu_b_resp, 2'b10);
      chk("pulse_aw_ready", cpu_aw_ready, 1);
      cpu_aw_valid = 1; cpu_id = 4'h2;
      cpu_addr = 64'h2008; cpu_len = 0; cpu_size = 2'b11;
      tick;
      cpu_aw_valid = 0;
      #1;
      chk("pulse_req_aw", axi_aw_valid_o, 1);
      chk("pulse_req_addr", axi_aw_addr_o, 64'h2008);
      chk("pulse_end", cpu_b_valid, 0);
      chk("resp_hold", cpu_b_resp, 2'b10);
      axi_aw_ready_i = 1;
      tick;
      axi_aw_ready_i = 0;
      cpu_w_valid = 1; axi_w_ready_i = 1;
      tick;
      cpu_w_valid = 0; axi_w_ready_i = 0;
      axi_b_valid_i = 1; axi_b_resp_i = 2'b00;
      tick;
      axi_b_valid_i = 0;
      chk("pulse_req_resp", cpu_b_resp, 0);
      tick;

      // reset after 1 of 4 beats
      cpu_aw_valid = 1; cpu_addr = 64'h8000_0300;
      cpu_len = 8'd3; cpu_size = 2'b11;
      tick;
      cpu_aw_valid = 0;
      axi_aw_ready_i = 1;
      tick;
      axi_aw_ready_i = 0;
      cpu_w_valid = 1; axi_w_ready_i = 1;
      tick;
      reset = 1;
      tick;
      chk("mrst_aw_valid", axi_aw_valid_o, 0);
      chk("mrst_w_valid", axi_w_valid_o, 0);
      chk("mrst_w_ready", cpu_w_ready, 0);
      chk("mrst_b_ready", axi_b_ready_o, 0);
      chk("mrst_aw_ready", cpu_aw_ready, 1);
      reset = 0;
      cpu_w_valid = 0; axi_w_ready_i = 0;
      tick;
      run_single(vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
